cpu_trace_watchdog: RTL and testbench
=====================================

Name: cpu_trace_watchdog

Overview:
Synthesizable commit-trace capture and halt/timeout watchdog, attached beside cpu to record retired instructions.
- Captures the last DEPTH committed {PC, instruction} pairs into a circular buffer.
- Triggers on halt or on a cycle-count timeout.
- Keeps capturing for a programmable post-trigger window, then freezes.
- Contents are read out oldest-first for debug and self-checking benches.

Parameters:
PC_WIDTH, 16, width of committed PC
INSTR_WIDTH, 16, width of committed instruction word
DEPTH, 16, trace entries; power of two, >= 2
PTR_WIDTH, 4, log2(DEPTH)
TIMEOUT_CYCLES, 100000, cycles after arm with no halt before timeout trigger; >= 1
POST_TRIGGER, 4, cycles of continued capture after trigger; 0 allowed

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous reset, active-low (asserted at 0)
arm  in  1  start capture; honoured only in IDLE or DONE
commit_valid  in  1  one instruction retired this cycle
commit_pc  in  PC_WIDTH  PC of retired instruction
commit_instr  in  INSTR_WIDTH  retired instruction word
halt  in  1  HLT executed (level or pulse)
rd_en  in  1  read request
rd_index  in  PTR_WIDTH  entry offset, 0 = oldest
rd_pc  out  PC_WIDTH  read PC
rd_instr  out  INSTR_WIDTH  read instruction
rd_valid  out  1  read data valid
capturing  out  1  high in ARMED or POST
triggered  out  1  halt trigger occurred
timed_out  out  1  timeout trigger occurred
done  out  1  high in DONE
entry_count  out  PTR_WIDTH+1  valid entries, saturates at DEPTH

Behaviour:
- Reset (reset=0, async):
  - State IDLE; write pointer, entry_count, watchdog and post counters = 0.
  - All outputs = 0.
  - RAM contents are not cleared; they are unreachable because entry_count=0.
- States:
  - IDLE: commits ignored. arm=1 -> ARMED, clearing pointer, count, watchdog, triggered, timed_out.
  - ARMED:
    - Each commit_valid writes {commit_pc, commit_instr} at wr_ptr; wr_ptr = (wr_ptr+1) mod DEPTH; entry_count++ saturating at DEPTH.
    - Watchdog increments every cycle.
    - halt=1 -> triggered=1, go to POST (or DONE if POST_TRIGGER=0).
    - Else if watchdog reaches TIMEOUT_CYCLES (the TIMEOUT_CYCLES-th cycle after arm) -> timed_out=1, same transition.
    - halt and timeout in the same cycle: halt wins; timed_out stays 0.
    - A commit in the trigger cycle is captured.
  - POST: capture continues. Post counter loads POST_TRIGGER on entry and decrements every cycle; at 0 -> DONE. Further halt has no effect.
  - DONE: capture stops; flags and buffer held. arm=1 -> ARMED, same clearing as from IDLE.
  - arm in ARMED or POST is ignored.
- Readout:
  - Allowed in any state; 1-cycle latency; output registered on the next rising edge.
  - Physical address = (oldest + rd_index) mod DEPTH, where oldest = 0 if entry_count < DEPTH, else wr_ptr.
  - If rd_index >= entry_count: rd_valid=0 and data=0.
  - rd_en=0: rd_valid=0 next cycle; data holds its last value.
  - Read and write to the same slot in one cycle: read returns the pre-write contents.
- Widths:
  - Watchdog counter is wide enough for TIMEOUT_CYCLES and saturates.
  - Pointer wrap is modulo DEPTH with no overflow flag; entry_count alone indicates wrap.

Test Plan:
(All scenarios use DEPTH=4, PTR_WIDTH=2, TIMEOUT_CYCLES=20, POST_TRIGGER=2.)
1. Reset mid-capture: arm, 3 commits, pull reset low asynchronously between edges -> all outputs 0 immediately; after release, entry_count=0, read index 0 gives rd_valid=0.
2. Wrap: arm, commit PCs 0x10,0x11,...,0x15 (6 commits), then halt -> entry_count=4, triggered=1; reads of index 0..3 return PCs 0x12,0x13,0x14,0x15 one cycle after each rd_en.
3. Post window: halt in cycle of commit PC 0x20, commits 0x21,0x22,0x23 on the next 3 cycles -> 0x20,0x21,0x22 captured, 0x23 not; done=1 two cycles after trigger.
4. Timeout: arm, no halt for 20 cycles -> timed_out=1, triggered=0; done=1 two cycles later; arm from DONE clears timed_out and entry_count.
5. Simultaneous: halt asserted on the exact cycle watchdog hits 20 -> triggered=1, timed_out=0.
6. Partial fill and ignored arm: arm, 2 commits, halt, arm again during POST (ignored) -> entry_count=2; read index 3 gives rd_valid=0, rd_pc=0.

Source files
------------

// File: rtl/cpu_trace_watchdog.sv
// rtl/cpu_trace_watchdog.sv - commit-trace circular buffer with halt/timeout trigger and post-trigger window
module cpu_trace_watchdog #(
    parameter int PC_WIDTH       = 16,
    parameter int INSTR_WIDTH    = 16,
    parameter int DEPTH          = 16,
    parameter int PTR_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int POST_TRIGGER   = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   arm,
    input  logic                   commit_valid,
    input  logic [PC_WIDTH-1:0]    commit_pc,
    input  logic [INSTR_WIDTH-1:0] commit_instr,
    input  logic                   halt,
    input  logic                   rd_en,
    input  logic [PTR_WIDTH-1:0]   rd_index,
    output logic [PC_WIDTH-1:0]    rd_pc,
    output logic [INSTR_WIDTH-1:0] rd_instr,
    output logic                   rd_valid,
    output logic                   capturing,
    output logic                   triggered,
    output logic                   timed_out,
    output logic                   done,
    output logic [PTR_WIDTH:0]     entry_count
);

    localparam int ENTRY_W = PC_WIDTH + INSTR_WIDTH;
    localparam int WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int POST_W  = (POST_TRIGGER > 0) ? $clog2(POST_TRIGGER + 1) : 1;

    localparam logic [PTR_WIDTH:0] FULL      = (PTR_WIDTH + 1)'(DEPTH);
    localparam logic [WD_W-1:0]    WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0]    WD_MAX    = WD_W'(TIMEOUT_CYCLES);
    localparam logic [POST_W-1:0]  POST_LOAD = POST_W'(POST_TRIGGER);

    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_POST, ST_DONE} state_t;

    state_t                 state_q, state_d;
    logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH:0]     count_q, count_d;
    logic [WD_W-1:0]        wd_q, wd_d;
    logic [POST_W-1:0]      post_q, post_d;
    logic                   triggered_q, triggered_d;
    logic                   timed_out_q, timed_out_d;
    logic [PC_WIDTH-1:0]    rd_pc_q, rd_pc_d;
    logic [INSTR_WIDTH-1:0] rd_instr_q, rd_instr_d;
    logic                   rd_valid_q, rd_valid_d;

    logic                   wr_en;
    logic                   trigger;
    logic [PTR_WIDTH-1:0]   oldest;
    logic [PTR_WIDTH-1:0]   rd_addr;
    logic                   rd_hit;

    logic [ENTRY_W-1:0]     mem_q [DEPTH];

    // Trace RAM: no reset, stale contents are hidden behind entry_count
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {commit_pc, commit_instr};
        end
    end

    // Control and readout state registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            wd_q        <= '0;
            post_q      <= '0;
            triggered_q <= 1'b0;
            timed_out_q <= 1'b0;
            rd_pc_q     <= '0;
            rd_instr_q  <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            wd_q        <= wd_d;
            post_q      <= post_d;
            triggered_q <= triggered_d;
            timed_out_q <= timed_out_d;
            rd_pc_q     <= rd_pc_d;
            rd_instr_q  <= rd_instr_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    // Next-state: arming, capture, watchdog, trigger priority and post window
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        wd_d        = wd_q;
        post_d      = post_q;
        triggered_d = triggered_q;
        timed_out_d = timed_out_q;
        wr_en       = 1'b0;
        trigger     = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    state_d     = ST_ARMED;
                    wr_ptr_d    = '0;
                    count_d     = '0;
                    wd_d        = '0;
                    post_d      = '0;
                    triggered_d = 1'b0;
                    timed_out_d = 1'b0;
                end
            end
            ST_ARMED: begin
                wr_en = commit_valid;
                if (wd_q != WD_MAX) begin
                    wd_d = wd_q + WD_W'(1);
                end
                // Halt has priority so a coincident timeout is not reported
                if (halt) begin
                    triggered_d = 1'b1;
                    trigger     = 1'b1;
                end else if (wd_q == WD_LAST) begin
                    timed_out_d = 1'b1;
                    trigger     = 1'b1;
                end
                if (trigger) begin
                    if (POST_LOAD == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_POST;
                        post_d  = POST_LOAD;
                    end
                end
            end
            ST_POST: begin
                wr_en = commit_valid;
                // Leave on the cycle the counter would reach zero
                if (post_q <= POST_W'(1)) begin
                    post_d  = '0;
                    state_d = ST_DONE;
                end else begin
                    post_d = post_q - POST_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
            if (count_q != FULL) begin
                count_d = count_q + (PTR_WIDTH + 1)'(1);
            end
        end
    end

    // Oldest-first readout; pre-write RAM contents are seen on a same-slot collision
    always_comb begin
        oldest     = (count_q == FULL) ? wr_ptr_q : '0;
        rd_addr    = oldest + rd_index;
        rd_hit     = ({1'b0, rd_index} < count_q);
        rd_valid_d = rd_en & rd_hit;
        rd_pc_d    = rd_pc_q;
        rd_instr_d = rd_instr_q;
        if (rd_en) begin
            if (rd_hit) begin
                {rd_pc_d, rd_instr_d} = mem_q[rd_addr];
            end else begin
                rd_pc_d    = '0;
                rd_instr_d = '0;
            end
        end
    end

    assign rd_pc       = rd_pc_q;
    assign rd_instr    = rd_instr_q;
    assign rd_valid    = rd_valid_q;
    assign capturing   = (state_q == ST_ARMED) || (state_q == ST_POST);
    assign done        = (state_q == ST_DONE);
    assign triggered   = triggered_q;
    assign timed_out   = timed_out_q;
    assign entry_count = count_q;

endmodule

// File: tb/tb_cpu_trace_watchdog.sv
// tb/tb_cpu_trace_watchdog.sv - directed self-checking bench for cpu_trace_watchdog
module tb_cpu_trace_watchdog;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        arm = 1'b0;
    logic        commit_valid = 1'b0;
    logic [15:0] commit_pc = '0;
    logic [15:0] commit_instr = '0;
    logic        halt = 1'b0;
    logic        rd_en = 1'b0;
    logic [1:0]  rd_index = '0;
    logic [15:0] rd_pc;
    logic [15:0] rd_instr;
    logic        rd_valid;
    logic        capturing;
    logic        triggered;
    logic        timed_out;
    logic        done;
    logic [2:0]  entry_count;

    int errors = 0;
    int checks = 0;

    cpu_trace_watchdog #(
        .PC_WIDTH(16), .INSTR_WIDTH(16), .DEPTH(4), .PTR_WIDTH(2),
        .TIMEOUT_CYCLES(20), .POST_TRIGGER(2)
    ) dut (
        .clock(clock), .reset(reset), .arm(arm), .commit_valid(commit_valid),
        .commit_pc(commit_pc), .commit_instr(commit_instr), .halt(halt),
        .rd_en(rd_en), .rd_index(rd_index), .rd_pc(rd_pc), .rd_instr(rd_instr),
        .rd_valid(rd_valid), .capturing(capturing), .triggered(triggered),
        .timed_out(timed_out), .done(done), .entry_count(entry_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic commit(input logic [15:0] pc);
        commit_valid = 1'b1;
        commit_pc    = pc;
        commit_instr = 16'hA500 | pc;
        tick();
        commit_valid = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({capturing, triggered, timed_out, done, rd_valid, entry_count, rd_pc, rd_instr} !== 40'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {capturing, triggered, timed_out, done, rd_valid, entry_count, rd_pc, rd_instr});
        end
        reset = 1'b1;
        tick();
        do_arm();
        commit(16'h30);
        commit(16'h31);
        commit(16'h32);
        rd_en = 1'b1; rd_index = 2'd0;
        tick();
        rd_en = 1'b0;
        checks++;
        if (rd_pc !== 16'h30 || entry_count !== 3'd3 || capturing !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_state: got pc=%h cnt=%0d cap=%b expected pc=0030 cnt=3 cap=1", rd_pc, entry_count, capturing);
        end
        #3 reset = 1'b0;
        #1;
        checks++;
        if ({capturing, triggered, timed_out, done, rd_valid, entry_count, rd_pc, rd_instr} !== 40'd0) begin
            errors++;
            $display("FAIL async_reset_outputs: got %h expected 0", {capturing, triggered, timed_out, done, rd_valid, entry_count, rd_pc, rd_instr});
        end
        #1 reset = 1'b1;
        tick();
        rd_en = 1'b1; rd_index = 2'd0;
        tick();
        rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b0 || entry_count !== 3'd0 || capturing !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_read: got valid=%b cnt=%0d cap=%b expected 0 0 0", rd_valid, entry_count, capturing);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_pc;
        do_arm();
        for (int i = 0; i < 6; i++) commit(16'h10 + 16'(i));
        halt = 1'b1;
        tick();
        halt = 1'b0;
        checks++;
        if (entry_count !== 3'd4 || triggered !== 1'b1 || timed_out !== 1'b0) begin
            errors++;
            $display("FAIL wrap_state: got cnt=%0d trig=%b to=%b expected 4 1 0", entry_count, triggered, timed_out);
        end
        for (int i = 0; i < 4; i++) begin
            rd_en = 1'b1; rd_index = 2'(i);
            tick();
            exp_pc = 16'h12 + 16'(i);
            checks++;
            if (rd_valid !== 1'b1 || rd_pc !== exp_pc || rd_instr !== (16'hA500 | exp_pc)) begin
                errors++;
                $display("FAIL wrap_read%0d: got v=%b pc=%h ins=%h expected v=1 pc=%h ins=%h", i, rd_valid, rd_pc, rd_instr, exp_pc, 16'hA500 | exp_pc);
            end
        end
        rd_en = 1'b0;
        tick();
        checks++;
        if (rd_valid !== 1'b0 || rd_pc !== 16'h15) begin
            errors++;
            $display("FAIL read_hold: got v=%b pc=%h expected v=0 pc=0015", rd_valid, rd_pc);
        end
        checks++;
        if (done !== 1'b1 || capturing !== 1'b0) begin
            errors++;
            $display("FAIL wrap_done: got done=%b cap=%b expected 1 0", done, capturing);
        end
    endtask

    task automatic test_post_window();
        do_arm();
        halt = 1'b1;
        commit(16'h20);
        halt = 1'b0;
        checks++;
        if (triggered !== 1'b1 || capturing !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL post_enter: got trig=%b cap=%b done=%b expected 1 1 0", triggered, capturing, done);
        end
        commit(16'h21);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL post_early_done: got done=%b expected 0", done);
        end
        commit(16'h22);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL post_done: got done=%b expected 1", done);
        end
        commit(16'h23);
        checks++;
        if (entry_count !== 3'd3) begin
            errors++;
            $display("FAIL post_count: got %0d expected 3", entry_count);
        end
        for (int i = 0; i < 3; i++) begin
            rd_en = 1'b1; rd_index = 2'(i);
            tick();
            checks++;
            if (rd_valid !== 1'b1 || rd_pc !== 16'h20 + 16'(i)) begin
                errors++;
                $display("FAIL post_read%0d: got v=%b pc=%h expected v=1 pc=%h", i, rd_valid, rd_pc, 16'h20 + 16'(i));
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_timeout();
        do_arm();
        commit(16'h40);
        for (int i = 0; i < 18; i++) tick();
        checks++;
        if (timed_out !== 1'b0 || capturing !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: got to=%b cap=%b expected 0 1", timed_out, capturing);
        end
        tick();
        checks++;
        if (timed_out !== 1'b1 || triggered !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL timeout_fire: got to=%b trig=%b done=%b expected 1 0 0", timed_out, triggered, done);
        end
        tick();
        tick();
        checks++;
        if (done !== 1'b1 || entry_count !== 3'd1) begin
            errors++;
            $display("FAIL timeout_done: got done=%b cnt=%0d expected 1 1", done, entry_count);
        end
        do_arm();
        checks++;
        if (timed_out !== 1'b0 || entry_count !== 3'd0 || capturing !== 1'b1) begin
            errors++;
            $display("FAIL rearm_clear: got to=%b cnt=%0d cap=%b expected 0 0 1", timed_out, entry_count, capturing);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 19; i++) tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        checks++;
        if (triggered !== 1'b1 || timed_out !== 1'b0) begin
            errors++;
            $display("FAIL simultaneous: got trig=%b to=%b expected 1 0", triggered, timed_out);
        end
        tick();
        tick();
    endtask

    task automatic test_partial_ignored_arm();
        do_arm();
        commit(16'h50);
        commit(16'h51);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        checks++;
        if (entry_count !== 3'd2 || triggered !== 1'b1 || capturing !== 1'b1) begin
            errors++;
            $display("FAIL ignored_arm: got cnt=%0d trig=%b cap=%b expected 2 1 1", entry_count, triggered, capturing);
        end
        rd_en = 1'b1; rd_index = 2'd1;
        tick();
        checks++;
        if (rd_valid !== 1'b1 || rd_pc !== 16'h51) begin
            errors++;
            $display("FAIL partial_read1: got v=%b pc=%h expected v=1 pc=0051", rd_valid, rd_pc);
        end
        rd_index = 2'd3;
        tick();
        rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b0 || rd_pc !== 16'h0 || rd_instr !== 16'h0) begin
            errors++;
            $display("FAIL partial_read3: got v=%b pc=%h ins=%h expected 0 0000 0000", rd_valid, rd_pc, rd_instr);
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_post_window();
        test_timeout();
        test_simultaneous();
        test_partial_ignored_arm();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
